wr_err_responder: RTL and testbench
===================================

# wr_err_responder

Write-channel front end placed directly upstream of `write_guard`, between the AXI master and the monitored slave. In normal operation it passes AW/W/B through unchanged and pulses `wr_en_o` for every AW handshake, which feeds the guard's enqueue input. When the guard raises its reset request, the block isolates the slave and terminates every further write from the master locally with an SLVERR B response, so the master never hangs on a slave that is being reset.

## Interface
- `MaxWrTxns`, 32: max forwarded AWs whose W burst is still incomplete; matches guard `MaxWrTxns`.
- `ErrCntWidth`, 16: width of the error-response counter.
- `req_t`, logic: AXI request struct (aw, aw_valid, w, w_valid, b_ready, ...).
- `rsp_t`, logic: AXI response struct (aw_ready, w_ready, b, b_valid, ...).
- `id_t`, logic: AXI ID type.
- `clk_i`  in  1  clock; single clock domain.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `reset_req_i`  in  1  isolation request from `write_guard.reset_req_o`.
- `mst_req_i`  in  req_t  request from master.
- `mst_rsp_o`  out  rsp_t  response to master.
- `slv_req_o`  out  req_t  request to slave.
- `slv_rsp_i`  in  rsp_t  response from slave.
- `wr_en_o`  out  1  one-cycle pulse per forwarded AW handshake; drives guard `wr_en_i`.
- `isolated_o`  out  1  high while the block is not in PASS.
- `err_cnt_o`  out  ErrCntWidth  saturating count of locally generated SLVERR responses.

## Operation
- Mode FSM has 4 states. Reset state is PASS.
  - PASS: all channels connected combinationally. Exceptions: `slv_req_o.aw_valid` and `mst_rsp_o.aw_ready` are gated low while `w_pend == MaxWrTxns`. `wr_en_o = mst aw_valid & slv aw_ready & ~gate`.
  - ERR_IDLE, ERR_W, ERR_B are the isolated states.
- `iso = reset_req_i | (state != PASS)`. The slave-side gating is combinational on `iso`.
- While `iso` is high:
  - `slv_req_o` has aw_valid/w_valid = 0 and b_ready = 1, so stale slave Bs are dropped.
  - `mst_rsp_o` takes aw_ready/w_ready/b from the responder only. Slave signals are ignored.
- `w_pend` counter, width `$clog2(MaxWrTxns+1)`:
  - +1 on each forwarded AW handshake.
  - -1 on each W handshake with w.last, whether forwarded or absorbed.
  - Both events in the same cycle: unchanged.
  - Never wraps.
- PASS -> ERR_IDLE when `reset_req_i == 1`.
- ERR_IDLE:
  - If `w_pend > 0`: w_ready = 1 and aw_ready = 0. Stale bursts are absorbed until `w_pend` reaches 0.
  - Otherwise: aw_ready = 1. On AW handshake, latch `aw.id` into `err_id` and go to ERR_W.
  - If `reset_req_i == 0` and `w_pend == 0` with no AW handshake this cycle: go to PASS.
- ERR_W: w_ready = 1, aw_ready = 0. On W handshake with last, go to ERR_B.
- ERR_B:
  - b_valid = 1, b.id = `err_id`, b.resp = 2'b10 (SLVERR).
  - On b_ready, increment `err_cnt` (saturating at all-ones) and go to ERR_IDLE.
- Bs for AWs forwarded before isolation are not synthesised. They are dropped, and the guard's reset/IRQ path covers them.
- W data arriving before its AW in isolation is not accepted: w_ready = 0 in ERR_IDLE when `w_pend == 0`.

## Timing
- Reset values:
  - state = PASS, `w_pend` = 0, `err_cnt` = 0, `err_id` = 0.
  - `wr_en_o` = 0 and `isolated_o` = 0.
  - In PASS, `mst_rsp_o` and `slv_req_o` mirror their inputs.
- PASS path: zero-cycle combinational latency on all channels.
- Isolation takes effect in the same cycle `reset_req_i` rises, combinationally via `iso`. The state register follows one cycle later.
- `isolated_o` is registered: high from the cycle after `reset_req_i` rises until the cycle after the return to PASS.
- Local error transaction costs at least 1 cycle AW + (len+1) cycles W + 1 cycle B. B is registered: it asserts the cycle after the W last handshake.
- Return to PASS takes 1 cycle after the `reset_req_i` fall, provided the FSM is in ERR_IDLE with `w_pend == 0`. If the fall happens in ERR_W or ERR_B, the current error transaction completes first.
- b_valid stays high in ERR_B until b_ready. The b payload is stable while b_valid is high.
- Asynchronous reset mid-transaction immediately returns all state to the reset values.

## Test plan
- Pass-through: 3 AWs (id 1, 2, 3; len 3) with full W bursts and slave B OKAY -> all forwarded unchanged, `wr_en_o` pulses exactly 3 times, `w_pend` ends at 0, `err_cnt_o` = 0.
- Isolation with pending W: AW id 5 len 7 forwarded, 2 beats sent, then `reset_req_i` = 1 -> remaining 6 beats absorbed with slave w_valid = 0, no B for id 5, `w_pend` = 0.
- Error response: under isolation, AW id 9 len 3 plus 4 W beats -> exactly one B with id 9 and resp 2'b10, one cycle after the last beat; `err_cnt_o` = 1; slave sees no aw_valid.
- Backpressure: in ERR_B, hold b_ready = 0 for 5 cycles -> b_valid held with stable payload; counter increments only on the handshake.
- Release: `reset_req_i` falls during ERR_W -> the error transaction completes, the FSM returns to PASS in the cycle after ERR_IDLE is reached, and the next AW is forwarded with a `wr_en_o` pulse.
- Full/saturation: MaxWrTxns = 4; issue 4 AWs without W -> 5th AW sees aw_ready = 0; a single W last handshake in the same cycle as the 5th AW -> `w_pend` returns to 4 and the AW is accepted.

Source files
------------

// File: rtl/wr_err_responder.sv
`default_nettype none
// ============================================================================
// Module  : wr_err_responder
// Brief   : AXI write-channel front end that isolates the slave on a guard
//           reset request and answers further writes locally with SLVERR.
// Revision: 1.0 - initial release
// ============================================================================

package wr_err_responder_pkg;

    localparam int unsigned ID_WIDTH   = 4;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;

    typedef logic [ID_WIDTH-1:0] id_t;

    typedef struct packed {
        id_t                   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } aw_chan_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]   data;
        logic [DATA_WIDTH/8-1:0] strb;
        logic                    last;
    } w_chan_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
    } rsp_t;

endpackage

module wr_err_responder #(
    parameter int unsigned MaxWrTxns   = 32,
    parameter int unsigned ErrCntWidth = 16,
    parameter type         req_t       = wr_err_responder_pkg::req_t,
    parameter type         rsp_t       = wr_err_responder_pkg::rsp_t,
    parameter type         id_t        = wr_err_responder_pkg::id_t
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   reset_req_i,
    input  req_t                   mst_req_i,
    output rsp_t                   mst_rsp_o,
    output req_t                   slv_req_o,
    input  rsp_t                   slv_rsp_i,
    output logic                   wr_en_o,
    output logic                   isolated_o,
    output logic [ErrCntWidth-1:0] err_cnt_o
);

    localparam int unsigned            c_pend_w      = $clog2(MaxWrTxns + 1);
    localparam logic [c_pend_w-1:0]    c_pend_max    = c_pend_w'(MaxWrTxns);
    localparam logic [c_pend_w-1:0]    c_pend_one    = c_pend_w'(1);
    localparam logic [ErrCntWidth-1:0] c_cnt_one     = ErrCntWidth'(1);
    localparam logic [1:0]             c_resp_slverr = 2'b10;

    typedef enum logic [1:0] {
        PASS     = 2'd0,
        ERR_IDLE = 2'd1,
        ERR_W    = 2'd2,
        ERR_B    = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_pend_w-1:0]    r_w_pend;
    logic [ErrCntWidth-1:0] r_err_cnt;
    id_t                    r_err_id;
    logic                   r_isolated;

    logic w_iso;
    logic w_full;
    logic w_pend_nz;
    logic w_aw_fwd;
    logic w_aw_err;
    logic w_w_dec;
    logic w_b_done;
    req_t w_slv_req;
    rsp_t w_mst_rsp;

    assign w_iso     = reset_req_i | (r_state != PASS);
    assign w_full    = (r_w_pend == c_pend_max);
    assign w_pend_nz = (r_w_pend != '0);

    assign w_aw_fwd  = ~w_iso & mst_req_i.aw_valid & slv_rsp_i.aw_ready & ~w_full;
    assign w_aw_err  = (r_state == ERR_IDLE) & ~w_pend_nz & mst_req_i.aw_valid;
    // Only bursts of forwarded AWs are tracked; locally terminated bursts see w_pend == 0.
    assign w_w_dec   = mst_req_i.w_valid & w_mst_rsp.w_ready & mst_req_i.w.last & w_pend_nz;
    assign w_b_done  = (r_state == ERR_B) & mst_req_i.b_ready;

    always_comb begin
        w_slv_req = mst_req_i;
        w_mst_rsp = slv_rsp_i;
        if (!w_iso) begin
            w_slv_req.aw_valid = mst_req_i.aw_valid & ~w_full;
            w_mst_rsp.aw_ready = slv_rsp_i.aw_ready & ~w_full;
        end else begin
            w_slv_req.aw_valid = 1'b0;
            w_slv_req.w_valid  = 1'b0;
            w_slv_req.b_ready  = 1'b1;
            w_mst_rsp          = '0;
            case (r_state)
                ERR_IDLE: begin
                    if (w_pend_nz) begin
                        w_mst_rsp.w_ready = 1'b1;
                    end else begin
                        w_mst_rsp.aw_ready = 1'b1;
                    end
                end
                ERR_W: begin
                    w_mst_rsp.w_ready = 1'b1;
                end
                ERR_B: begin
                    w_mst_rsp.b_valid = 1'b1;
                    w_mst_rsp.b.id    = r_err_id;
                    w_mst_rsp.b.resp  = c_resp_slverr;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PASS: begin
                if (reset_req_i) begin
                    w_state_nxt = ERR_IDLE;
                end
            end
            ERR_IDLE: begin
                if (!w_pend_nz) begin
                    if (mst_req_i.aw_valid) begin
                        w_state_nxt = ERR_W;
                    end else if (!reset_req_i) begin
                        w_state_nxt = PASS;
                    end
                end
            end
            ERR_W: begin
                if (mst_req_i.w_valid && mst_req_i.w.last) begin
                    w_state_nxt = ERR_B;
                end
            end
            ERR_B: begin
                if (mst_req_i.b_ready) begin
                    w_state_nxt = ERR_IDLE;
                end
            end
            default: w_state_nxt = PASS;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= PASS;
            r_w_pend   <= '0;
            r_err_cnt  <= '0;
            r_err_id   <= '0;
            r_isolated <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_isolated <= w_iso;
            if (w_aw_fwd && !w_w_dec) begin
                r_w_pend <= r_w_pend + c_pend_one;
            end else if (w_w_dec && !w_aw_fwd) begin
                r_w_pend <= r_w_pend - c_pend_one;
            end
            if (w_aw_err) begin
                r_err_id <= mst_req_i.aw.id;
            end
            if (w_b_done && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + c_cnt_one;
            end
        end
    end

    assign mst_rsp_o  = w_mst_rsp;
    assign slv_req_o  = w_slv_req;
    assign wr_en_o    = w_aw_fwd;
    assign isolated_o = r_isolated;
    assign err_cnt_o  = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_wr_err_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_wr_err_responder
// Brief   : Directed self-checking bench for wr_err_responder (MaxWrTxns = 4).
// Revision: 1.0 - initial release
// ============================================================================

module tb_wr_err_responder;

    import wr_err_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reset_req;
    req_t        mst_req;
    rsp_t        mst_rsp;
    req_t        slv_req;
    rsp_t        slv_rsp;
    logic        wr_en;
    logic        isolated;
    logic [15:0] err_cnt;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    wr_err_responder #(
        .MaxWrTxns   (4),
        .ErrCntWidth (16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .reset_req_i (reset_req),
        .mst_req_i   (mst_req),
        .mst_rsp_o   (mst_rsp),
        .slv_req_o   (slv_req),
        .slv_rsp_i   (slv_rsp),
        .wr_en_o     (wr_en),
        .isolated_o  (isolated),
        .err_cnt_o   (err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && wr_en) wr_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_drive(input logic [3:0] id, input logic [7:0] len);
        mst_req.aw_valid = 1'b1;
        mst_req.aw.id    = id;
        mst_req.aw.len   = len;
        mst_req.aw.addr  = 32'h1000 + 32'(id);
    endtask

    task automatic w_drive(input logic [31:0] d, input logic last);
        mst_req.w_valid = 1'b1;
        mst_req.w.data  = d;
        mst_req.w.strb  = '1;
        mst_req.w.last  = last;
    endtask

    initial begin
        rst_n     = 1'b0;
        reset_req = 1'b0;
        mst_req   = '0;
        slv_rsp   = '0;
        slv_rsp.aw_ready = 1'b1;
        slv_rsp.w_ready  = 1'b1;

        // Reset state and PASS mirroring
        #1;
        chk("rst_isolated", 32'(isolated), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        w_drive(32'hA5, 1'b0);
        #1;
        chk("rst_mirror_wvalid", 32'(slv_req.w_valid), 32'd1);
        chk("rst_mirror_wdata", slv_req.w.data, 32'hA5);
        mst_req.w_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Pass-through: three AWs of len 3
        for (int id = 1; id <= 3; id++) begin
            aw_drive(4'(id), 8'd3);
            #1;
            chk("pt_slv_awvalid", 32'(slv_req.aw_valid), 32'd1);
            chk("pt_slv_awid", 32'(slv_req.aw.id), 32'(id));
            chk("pt_mst_awready", 32'(mst_rsp.aw_ready), 32'd1);
            chk("pt_wr_en", 32'(wr_en), 32'd1);
            tick();
            mst_req.aw_valid = 1'b0;
            for (int b = 0; b < 4; b++) begin
                w_drive(32'(id * 16 + b), b == 3);
                #1;
                chk("pt_slv_wdata", slv_req.w.data, 32'(id * 16 + b));
                chk("pt_mst_wready", 32'(mst_rsp.w_ready), 32'd1);
                tick();
            end
            mst_req.w_valid  = 1'b0;
            slv_rsp.b_valid  = 1'b1;
            slv_rsp.b.id     = 4'(id);
            slv_rsp.b.resp   = 2'b00;
            mst_req.b_ready  = 1'b1;
            #1;
            chk("pt_mst_bvalid", 32'(mst_rsp.b_valid), 32'd1);
            chk("pt_mst_bid", 32'(mst_rsp.b.id), 32'(id));
            chk("pt_mst_bresp", 32'(mst_rsp.b.resp), 32'd0);
            tick();
            slv_rsp.b_valid = 1'b0;
        end
        chk("pt_wr_en_count", 32'(wr_cnt), 32'd3);
        chk("pt_err_cnt", 32'(err_cnt), 32'd0);
        slv_rsp.aw_ready = 1'b0;
        aw_drive(4'd4, 8'd0);
        #1;
        chk("pt_awready_backpressure", 32'(mst_rsp.aw_ready), 32'd0);
        chk("pt_wr_en_backpressure", 32'(wr_en), 32'd0);
        mst_req.aw_valid = 1'b0;
        slv_rsp.aw_ready = 1'b1;

        // Isolation with a pending burst: AW id 5 len 7, two beats, then reset_req
        aw_drive(4'd5, 8'd7);
        #1;
        chk("iso_wr_en", 32'(wr_en), 32'd1);
        tick();
        mst_req.aw_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            w_drive(32'(80 + b), 1'b0);
            tick();
        end
        reset_req       = 1'b1;
        mst_req.b_ready = 1'b0;
        w_drive(32'd82, 1'b0);
        #1;
        chk("iso_same_cycle_wready", 32'(mst_rsp.w_ready), 32'd0);
        chk("iso_same_cycle_slv_wvalid", 32'(slv_req.w_valid), 32'd0);
        tick();
        chk("iso_isolated", 32'(isolated), 32'd1);
        chk("iso_awready_pending", 32'(mst_rsp.aw_ready), 32'd0);
        slv_rsp.b_valid = 1'b1;
        slv_rsp.b.id    = 4'd5;
        #1;
        chk("iso_stale_b_dropped", 32'(mst_rsp.b_valid), 32'd0);
        chk("iso_slv_bready", 32'(slv_req.b_ready), 32'd1);
        tick();
        slv_rsp.b_valid = 1'b0;
        for (int b = 2; b < 8; b++) begin
            w_drive(32'(80 + b), b == 7);
            #1;
            chk("iso_absorb_wready", 32'(mst_rsp.w_ready), 32'd1);
            chk("iso_absorb_slv_wvalid", 32'(slv_req.w_valid), 32'd0);
            tick();
        end
        mst_req.w_valid = 1'b0;
        #1;
        chk("iso_drained_awready", 32'(mst_rsp.aw_ready), 32'd1);
        chk("iso_drained_wready", 32'(mst_rsp.w_ready), 32'd0);

        // Local error response: AW id 9 len 3
        aw_drive(4'd9, 8'd3);
        #1;
        chk("err_awready", 32'(mst_rsp.aw_ready), 32'd1);
        chk("err_slv_awvalid", 32'(slv_req.aw_valid), 32'd0);
        chk("err_wr_en", 32'(wr_en), 32'd0);
        tick();
        mst_req.aw_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            w_drive(32'(90 + b), b == 3);
            #1;
            chk("err_wready", 32'(mst_rsp.w_ready), 32'd1);
            chk("err_bvalid_early", 32'(mst_rsp.b_valid), 32'd0);
            tick();
        end
        mst_req.w_valid = 1'b0;

        // Backpressure on the local B
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_bvalid", 32'(mst_rsp.b_valid), 32'd1);
            chk("bp_bid", 32'(mst_rsp.b.id), 32'd9);
            chk("bp_bresp", 32'(mst_rsp.b.resp), 32'd2);
            chk("bp_err_cnt_hold", 32'(err_cnt), 32'd0);
            tick();
        end
        mst_req.b_ready = 1'b1;
        #1;
        chk("bp_bvalid_hs", 32'(mst_rsp.b_valid), 32'd1);
        tick();
        mst_req.b_ready = 1'b0;
        #1;
        chk("bp_err_cnt_one", 32'(err_cnt), 32'd1);
        chk("bp_bvalid_after", 32'(mst_rsp.b_valid), 32'd0);
        chk("bp_back_idle_awready", 32'(mst_rsp.aw_ready), 32'd1);

        // Release while in ERR_W
        aw_drive(4'd10, 8'd1);
        tick();
        mst_req.aw_valid = 1'b0;
        reset_req        = 1'b0;
        w_drive(32'd100, 1'b0);
        #1;
        chk("rel_wready", 32'(mst_rsp.w_ready), 32'd1);
        chk("rel_isolated", 32'(isolated), 32'd1);
        tick();
        w_drive(32'd101, 1'b1);
        tick();
        mst_req.w_valid = 1'b0;
        mst_req.b_ready = 1'b1;
        #1;
        chk("rel_bvalid", 32'(mst_rsp.b_valid), 32'd1);
        chk("rel_bid", 32'(mst_rsp.b.id), 32'd10);
        tick();
        #1;
        chk("rel_err_cnt", 32'(err_cnt), 32'd2);
        chk("rel_idle_bvalid", 32'(mst_rsp.b_valid), 32'd0);
        tick();
        aw_drive(4'd11, 8'd0);
        #1;
        chk("rel_pass_slv_awvalid", 32'(slv_req.aw_valid), 32'd1);
        chk("rel_pass_slv_awid", 32'(slv_req.aw.id), 32'd11);
        chk("rel_pass_wr_en", 32'(wr_en), 32'd1);
        tick();
        mst_req.aw_valid = 1'b0;
        #1;
        chk("rel_isolated_low", 32'(isolated), 32'd0);
        w_drive(32'hB, 1'b1);
        #1;
        chk("rel_pass_slv_wvalid", 32'(slv_req.w_valid), 32'd1);
        tick();
        mst_req.w_valid = 1'b0;

        // Full: four AWs without W, fifth gated until a W last retires one
        for (int k = 0; k < 4; k++) begin
            aw_drive(4'(k), 8'd0);
            #1;
            chk("full_fill_wr_en", 32'(wr_en), 32'd1);
            tick();
        end
        aw_drive(4'd5, 8'd0);
        w_drive(32'hC, 1'b1);
        #1;
        chk("full_awready", 32'(mst_rsp.aw_ready), 32'd0);
        chk("full_slv_awvalid", 32'(slv_req.aw_valid), 32'd0);
        chk("full_wr_en", 32'(wr_en), 32'd0);
        chk("full_wready", 32'(mst_rsp.w_ready), 32'd1);
        tick();
        mst_req.w_valid = 1'b0;
        #1;
        chk("full_retry_awready", 32'(mst_rsp.aw_ready), 32'd1);
        chk("full_retry_wr_en", 32'(wr_en), 32'd1);
        tick();
        #1;
        chk("full_again_awready", 32'(mst_rsp.aw_ready), 32'd0);

        // Asynchronous reset mid-traffic clears pending count and error counter
        rst_n = 1'b0;
        #1;
        chk("arst_awready", 32'(mst_rsp.aw_ready), 32'd1);
        chk("arst_err_cnt", 32'(err_cnt), 32'd0);
        chk("arst_isolated", 32'(isolated), 32'd0);
        mst_req.aw_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
